// File: rtl/board_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : board_pkg
//  Purpose  : Shared types and constants for the board_io glue block:
//             reset sequencer states, LED drive modes, LED polarity helper.
//  Revision : 1.0  initial release
// ============================================================================
package board_pkg;

    // Core reset sequencer states
    typedef enum logic [1:0] {
        ASSERT = 2'd0,
        HOLD   = 2'd1,
        RUN    = 2'd2
    } reset_state_t;

    // LED drive modes
    localparam int LED_MODE_DIRECT  = 0;
    localparam int LED_MODE_STRETCH = 1;

    // Output inversion for LED channel k: the lower bank follows the
    // configured polarity and the upper bank uses the opposite one.
    function automatic logic led_invert(input logic active_low, input int k);
        return active_low ^ (k >= 8);
    endfunction

endpackage : board_pkg
`default_nettype wire

// File: rtl/board_io_reset_pulse.sv
`default_nettype none
// ============================================================================
//  Module   : reset_pulse
//  Purpose  : Synchronises the external reset request and stretches its
//             release into a registered core reset of RESET_CYCLES cycles.
//  Revision : 1.0  initial release
// ============================================================================
module reset_pulse
    import board_pkg::*;
#(
    parameter int RESET_CYCLES = 8_000_000
) (
    input  logic clock,
    input  logic resn,
    input  logic ext_resn,
    output logic res
);

    localparam int            CW       = $clog2(RESET_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(RESET_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic         sync1_q;
    logic         req_n_q;
    reset_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         res_q, res_d;

    // Two-flop synchroniser; clearing to 0 makes a local reset look like a request.
    always_ff @(posedge clock or negedge resn) begin
        if (!resn) begin
            sync1_q <= 1'b0;
            req_n_q <= 1'b0;
        end else begin
            sync1_q <= ext_resn;
            req_n_q <= sync1_q;
        end
    end

    // State, hold counter and reset output registers.
    always_ff @(posedge clock or negedge resn) begin
        if (!resn) begin
            state_q <= ASSERT;
            cnt_q   <= CNT_LOAD;
            res_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    // Next state: a request from any state restarts the sequence in ASSERT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ASSERT: begin
                if (req_n_q) begin
                    state_d = HOLD;
                    cnt_d   = CNT_LOAD;
                end
            end
            HOLD: begin
                if (!req_n_q) begin
                    state_d = ASSERT;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!req_n_q) begin
                    state_d = ASSERT;
                end
            end
            default: begin
                state_d = ASSERT;
            end
        endcase
    end

    // Output: reset is held everywhere except RUN, registered for a clean edge.
    always_comb begin
        res_d = (state_d != RUN);
    end

    assign res = res_q;

endmodule : reset_pulse
`default_nettype wire

// File: rtl/board_io.sv
`default_nettype none
// ============================================================================
//  Module   : board_io
//  Purpose  : Board-level glue between FPGA pins and the core: bidirectional
//             pin mapping, USB serial bridge on pins 30/31, core reset
//             sequencing and a polarity-configurable, optionally stretched
//             LED bank.
//  Revision : 1.0  initial release
// ============================================================================
module board_io
    import board_pkg::*;
#(
    parameter int   NUM_PINS       = 30,
    parameter int   NUM_LEDS       = 16,
    parameter logic LED_ACTIVE_LOW = 1'b1,
    parameter int   LED_STRETCH    = 0,
    parameter int   STRETCH_CYCLES = 8_000_000,
    parameter int   RESET_CYCLES   = 8_000_000
) (
    input  logic                clock,
    input  logic                resn,
    input  logic                ext_resn,
    inout  wire  [NUM_PINS-1:0] io,
    input  logic                ser_rx,
    output logic                ser_tx,
    input  logic [31:0]         pin_out,
    input  logic [31:0]         pin_dir,
    output logic [31:0]         pin_in,
    input  logic [7:0]          led_src,
    output logic [NUM_LEDS-1:0] led,
    output logic                res
);

    localparam int            SW    = $clog2(STRETCH_CYCLES + 1);
    localparam logic [SW-1:0] SLOAD = SW'(STRETCH_CYCLES);
    localparam logic [SW-1:0] SONE  = SW'(1);

    // Core reset sequencer
    reset_pulse #(
        .RESET_CYCLES (RESET_CYCLES)
    ) u_reset_pulse (
        .clock    (clock),
        .resn     (resn),
        .ext_resn (ext_resn),
        .res      (res)
    );

    // Propeller pins 0..29: mapped pins are tristated, unmapped ones read 0.
    for (genvar i = 0; i < 30; i++) begin : g_pin
        if (i < NUM_PINS) begin : g_map
            assign io[i]     = pin_dir[i] ? pin_out[i] : 1'bz;
            assign pin_in[i] = io[i];
        end else begin : g_tie
            assign pin_in[i] = 1'b0;
        end
    end

    // Serial bridge: pin 30 reads high, TX idles high when the core is not driving.
    assign pin_in[30] = 1'b1;
    assign pin_in[31] = ser_rx;
    assign ser_tx     = pin_dir[30] ? pin_out[30] : 1'b1;

    // LED channels; channel k is sourced from led_src[k mod 8].
    for (genvar k = 0; k < NUM_LEDS; k++) begin : g_led
        logic w_src;
        logic w_on;

        assign w_src = led_src[k % 8];

        if (LED_STRETCH == LED_MODE_STRETCH) begin : g_stretch
            logic          src_q;
            logic [SW-1:0] scnt_q, scnt_d;

            // Rising edge (re)loads the stretch counter, otherwise it drains to 0.
            always_comb begin
                scnt_d = scnt_q;
                if (w_src && !src_q) begin
                    scnt_d = SLOAD;
                end else if (scnt_q != '0) begin
                    scnt_d = scnt_q - SONE;
                end
            end

            // Source history for edge detection and the stretch counter.
            always_ff @(posedge clock or negedge resn) begin
                if (!resn) begin
                    src_q  <= 1'b0;
                    scnt_q <= '0;
                end else begin
                    src_q  <= w_src;
                    scnt_q <= scnt_d;
                end
            end

            assign w_on = w_src | (scnt_q != '0);
        end else begin : g_direct
            assign w_on = w_src;
        end

        // LEDs stay dark while the core is held in reset.
        assign led[k] = (w_on & ~res) ^ led_invert(LED_ACTIVE_LOW, k);
    end

    // Core bus bits that a given board configuration leaves unrouted.
    logic unused_ok;
    assign unused_ok = ^{pin_out, pin_dir, led_src};

endmodule : board_io
`default_nettype wire

// File: tb/tb_board_io.sv
`default_nettype none
// ============================================================================
//  Module   : tb_board_io
//  Purpose  : Self-checking bench for board_io: reset sequencing, pin map,
//             serial bridge, LED stretching/polarity and reset gating.
//  Revision : 1.0  initial release
// ============================================================================
module tb_board_io;

    localparam int RC = 10;
    localparam int SC = 5;

    logic        clock = 1'b0;
    logic        resn;
    logic        ext_resn;
    logic        ser_rx;
    logic [31:0] pin_out;
    logic [31:0] pin_dir;
    logic [31:0] pin_dir2;
    logic [7:0]  led_src;
    logic [3:0]  drv_en;
    logic [3:0]  drv_val;

    wire  [3:0]  io_s;
    wire  [3:0]  io_d;
    logic        ser_tx_s, ser_tx_d;
    logic [31:0] pin_in_s, pin_in_d;
    logic [15:0] led_s, led_d;
    logic        res_s, res_d;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    for (genvar i = 0; i < 4; i++) begin : g_drv
        assign io_s[i] = drv_en[i] ? drv_val[i] : 1'bz;
    end
    assign io_d = 4'b1010;

    board_io #(
        .NUM_PINS(4), .NUM_LEDS(16), .LED_ACTIVE_LOW(1'b1),
        .LED_STRETCH(1), .STRETCH_CYCLES(SC), .RESET_CYCLES(RC)
    ) u_str (
        .clock(clock), .resn(resn), .ext_resn(ext_resn), .io(io_s),
        .ser_rx(ser_rx), .ser_tx(ser_tx_s), .pin_out(pin_out), .pin_dir(pin_dir),
        .pin_in(pin_in_s), .led_src(led_src), .led(led_s), .res(res_s)
    );

    board_io #(
        .NUM_PINS(4), .NUM_LEDS(16), .LED_ACTIVE_LOW(1'b0),
        .LED_STRETCH(0), .STRETCH_CYCLES(SC), .RESET_CYCLES(RC)
    ) u_dir (
        .clock(clock), .resn(resn), .ext_resn(ext_resn), .io(io_d),
        .ser_rx(ser_rx), .ser_tx(ser_tx_d), .pin_out(pin_out), .pin_dir(pin_dir2),
        .pin_in(pin_in_d), .led_src(led_src), .led(led_d), .res(res_d)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Apply up to two single-cycle pulses on led_src[0] and measure led[0]/led[8].
    task automatic run_pulses(input int second, output int run, output int lowcnt, output int badhi);
        bit ended;
        ended  = 1'b0;
        run    = 0;
        lowcnt = 0;
        badhi  = 0;
        for (int c = 0; c < 16; c++) begin
            led_src = {7'b0, (c == 0) || (c == second)};
            #1;
            if (led_s[0] == 1'b0) lowcnt++;
            if (led_s[8] !== ~led_s[0]) badhi++;
            if (!ended && led_s[0] == 1'b0) run++;
            else ended = 1'b1;
            tick();
        end
        led_src = 8'h00;
    endtask

    typedef struct {
        logic [31:0] dir;
        logic [31:0] out;
        logic [3:0]  drv;
        logic        rx;
        logic [31:0] exp_in;
        logic        exp_tx;
        logic [3:0]  exp_io;
    } pin_vec_t;

    pin_vec_t tv[6];

    int  n;
    bit  done;
    int  run, lowcnt, badhi;
    int  rise[8];
    logic [7:0]  prev, src;
    logic [15:0] exp_s, exp_d;

    initial begin
        tv[0] = '{32'h0000_0005, 32'h0000_000F, 4'b1000, 1'b0, 32'h4000_000D, 1'b1, 4'b1101};
        tv[1] = '{32'h4000_0000, 32'h4000_0000, 4'b1010, 1'b1, 32'hC000_000A, 1'b1, 4'b1010};
        tv[2] = '{32'h4000_0000, 32'h0000_0000, 4'b0101, 1'b1, 32'hC000_0005, 1'b0, 4'b0101};
        tv[3] = '{32'hFFFF_FFFF, 32'hAAAA_AAAA, 4'b0000, 1'b0, 32'h4000_000A, 1'b0, 4'b1010};
        tv[4] = '{32'hFFFF_FFF0, 32'h5555_5555, 4'b0011, 1'b1, 32'hC000_0003, 1'b1, 4'b0011};
        tv[5] = '{32'h0000_000A, 32'h0000_0008, 4'b0100, 1'b0, 32'h4000_000C, 1'b1, 4'b1100};

        resn     = 1'b0;
        ext_resn = 1'b1;
        led_src  = 8'hFF;
        ser_rx   = 1'b1;
        pin_dir  = 32'h0;
        pin_dir2 = 32'h0;
        pin_out  = 32'h0;
        drv_en   = 4'h0;
        drv_val  = 4'h0;

        // Power-on reset with all LED sources active: LEDs must stay dark.
        repeat (3) begin
            tick();
            chk("por_res_str", {31'b0, res_s}, 32'd1);
            chk("por_res_dir", {31'b0, res_d}, 32'd1);
            chk("por_led_str", {16'b0, led_s}, 32'h0000_00FF);
            chk("por_led_dir", {16'b0, led_d}, 32'h0000_FF00);
        end
        chk("por_ser_tx", {31'b0, ser_tx_s}, 32'd1);

        resn = 1'b1;
        n = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            tick();
            n++;
            if (res_s == 1'b0) done = 1'b1;
            else chk("hold_led_gate", {16'b0, led_s}, 32'h0000_00FF);
        end
        chk("por_release_cycles", n, 32'd13);
        chk("por_release_dir", {31'b0, res_d}, 32'd0);
        led_src = 8'h00;
        repeat (2) tick();

        // Request assertion reaches res within three cycles.
        ext_resn = 1'b0;
        n = 0;
        done = 1'b0;
        while (!done && n < 10) begin
            tick();
            n++;
            if (res_s == 1'b1) done = 1'b1;
        end
        chk("req_to_res_le3", {31'b0, (n >= 1 && n <= 3)}, 32'd1);
        repeat (2) tick();

        // Mid-count request: pulse ext_resn low when the hold counter reads 4.
        ext_resn = 1'b1;
        repeat (9) tick();
        chk("midcount_res_held", {31'b0, res_s}, 32'd1);
        ext_resn = 1'b0;
        tick();
        ext_resn = 1'b1;
        n = 0;
        done = 1'b0;
        while (!done && n < 40) begin
            tick();
            n++;
            if (res_s == 1'b0) done = 1'b1;
        end
        chk("midcount_release_cycles", n, 32'd13);

        // Pin mapping and serial bridge vectors.
        for (int v = 0; v < 6; v++) begin
            pin_dir = tv[v].dir;
            pin_out = tv[v].out;
            drv_en  = ~tv[v].dir[3:0];
            drv_val = tv[v].drv;
            ser_rx  = tv[v].rx;
            #1;
            chk("pin_in", pin_in_s, tv[v].exp_in);
            chk("ser_tx", {31'b0, ser_tx_s}, {31'b0, tv[v].exp_tx});
            chk("io_pins", {28'b0, io_s}, {28'b0, tv[v].exp_io});
        end
        chk("pin_in_dir_inst", {28'b0, pin_in_d[3:0]}, 32'h0000_000A);
        chk("ser_tx_dir_inst", {31'b0, ser_tx_d}, 32'd1);
        pin_dir = 32'h0;
        drv_en  = 4'h0;
        tick();

        // Single stretched pulse.
        led_src = 8'h00;
        repeat (8) tick();
        run_pulses(-1, run, lowcnt, badhi);
        chk("stretch_run", run, 32'd6);
        chk("stretch_total", lowcnt, 32'd6);
        chk("stretch_upper_bank", badhi, 32'd0);

        // Retriggered pulse.
        repeat (8) tick();
        run_pulses(3, run, lowcnt, badhi);
        chk("retrig_run", run, 32'd9);
        chk("retrig_total", lowcnt, 32'd9);
        chk("retrig_upper_bank", badhi, 32'd0);

        // Random LED traffic against a last-rising-edge timing model.
        repeat (8) tick();
        for (int j = 0; j < 8; j++) rise[j] = -100;
        prev = 8'h00;
        for (int m = 0; m < 300; m++) begin
            for (int j = 0; j < 8; j++) src[j] = ($urandom_range(0, 3) == 0);
            led_src = src;
            #1;
            for (int k = 0; k < 16; k++) begin
                exp_s[k] = (src[k % 8] || ((m - rise[k % 8]) >= 1 && (m - rise[k % 8]) <= SC)) ^ (k < 8);
                exp_d[k] = src[k % 8] ^ (k >= 8);
            end
            for (int j = 0; j < 8; j++) if (src[j] && !prev[j]) rise[j] = m;
            prev = src;
            chk("rand_led_stretch", {16'b0, led_s}, {16'b0, exp_s});
            chk("rand_led_direct", {16'b0, led_d}, {16'b0, exp_d});
            tick();
        end

        // Gating while a request holds the core in reset.
        ext_resn = 1'b0;
        led_src  = 8'hFF;
        repeat (4) tick();
        chk("gate_res", {31'b0, res_s}, 32'd1);
        chk("gate_led_str", {16'b0, led_s}, 32'h0000_00FF);
        chk("gate_led_dir", {16'b0, led_d}, 32'h0000_FF00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_board_io
`default_nettype wire
